tmds_period_scheduler: RTL and testbench

Sequences the three TMDS channel encoders of the video output path. Generates raster timing, chooses the period type per pixel clock (control, preamble, guard band, video), and drives per-channel control codes and 8-bit pixel data. Pulls RGB pixels from an upstream source over a ready/valid handshake. Sits between the frame/pattern source and the blue, green and red encoder instances.

---
 rtl/tmds_pkg.sv | 20 ++
 rtl/video_timing_counter.sv | 57 +++++
 rtl/tmds_period_scheduler.sv | 154 +++++++++++++++
 tb/tb_tmds_period_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared period encodings and TMDS constants for the period scheduler and the
// downstream channel encoders.
package tmds_pkg;

    typedef enum logic [1:0] {
        CONTROL  = 2'b00,
        PREAMBLE = 2'b01,
        GUARD    = 2'b10,
        VIDEO    = 2'b11
    } tmdsMode_t;

    // {CTL3,CTL2,CTL1,CTL0} announcing a video data period
    localparam logic [3:0] PREAMBLE_VIDEO_CTL = 4'b0001;

    // Guard-band symbols the encoder output mux substitutes while o_mode is GUARD
    localparam logic [9:0] GUARD_CH0 = 10'b1011001100;
    localparam logic [9:0] GUARD_CH1 = 10'b0100110011;
    localparam logic [9:0] GUARD_CH2 = 10'b1011001100;

endpackage

// File: rtl/video_timing_counter.sv
// Raster h/v counters with enable hold at (0,0), plus sync and active-line flags
// for the position that the scheduler will present on the next edge.
module video_timing_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [11:0] o_h,
    output logic        o_hsAct,
    output logic        o_vsAct,
    output logic        o_activeLine,
    output logic        o_origin
);

    localparam logic [11:0] L_H_LAST     = 12'(H_FP + H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [11:0] L_V_LAST     = 12'(V_FP + V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [11:0] L_V_BLANK    = 12'(V_FP + V_SYNC + V_BP);
    localparam logic [11:0] L_HS_FIRST   = 12'(H_FP);
    localparam logic [11:0] L_HS_LAST    = 12'(H_FP + H_SYNC - 1);
    localparam logic [11:0] L_VS_FIRST   = 12'(V_FP);
    localparam logic [11:0] L_VS_LAST    = 12'(V_FP + V_SYNC - 1);

    logic [11:0] r_hCount;
    logic [11:0] r_vCount;

    // The counters always hold the position to be presented at the next edge,
    // so parking them at (0,0) while disabled makes the first enabled edge show (0,0).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hCount <= '0;
            r_vCount <= '0;
        end else if (!i_en) begin
            r_hCount <= '0;
            r_vCount <= '0;
        end else if (r_hCount == L_H_LAST) begin
            r_hCount <= '0;
            r_vCount <= (r_vCount == L_V_LAST) ? 12'd0 : r_vCount + 12'd1;
        end else begin
            r_hCount <= r_hCount + 12'd1;
        end
    end

    assign o_h          = r_hCount;
    assign o_hsAct      = (r_hCount >= L_HS_FIRST) && (r_hCount <= L_HS_LAST);
    assign o_vsAct      = (r_vCount >= L_VS_FIRST) && (r_vCount <= L_VS_LAST);
    assign o_activeLine = (r_vCount >= L_V_BLANK);
    assign o_origin     = (r_hCount == 12'd0) && (r_vCount == 12'd0);

endmodule

// File: rtl/tmds_period_scheduler.sv
// Period scheduler for the three TMDS encoders: period FSM, pixel handshake and
// registered per-channel outputs. Define TMDS_HDMI_PERIODS_EN for HDMI preamble/guard periods.
module tmds_period_scheduler
    import tmds_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [23:0] i_pix,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    output logic [1:0]  o_mode,
    output logic [1:0]  o_ctrl0,
    output logic [1:0]  o_ctrl1,
    output logic [1:0]  o_ctrl2,
    output logic [7:0]  o_data0,
    output logic [7:0]  o_data1,
    output logic [7:0]  o_data2,
    output logic        o_frame_start,
    output logic        o_underflow
);

    localparam logic [11:0] L_H_BLANK   = 12'(H_FP + H_SYNC + H_BP);
    localparam logic [11:0] L_RDY_FIRST = 12'(H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] L_RDY_LAST  = 12'(H_FP + H_SYNC + H_BP + H_ACTIVE - 2);
    localparam logic        L_HS_ON     = (HS_POL != 0);
    localparam logic        L_VS_ON     = (VS_POL != 0);

    logic [11:0] w_hCount;
    logic        w_hsAct;
    logic        w_vsAct;
    logic        w_activeLine;
    logic        w_origin;
    logic        w_videoWin;
    logic        w_readyNext;

    tmdsMode_t   r_mode;
    tmdsMode_t   w_modeNext;
    logic [1:0]  r_ctrl0, r_ctrl1, r_ctrl2;
    logic [1:0]  w_ctrl0Next, w_ctrl1Next, w_ctrl2Next;
    logic [23:0] r_pix;
    logic [23:0] w_pixNext;
    logic        r_pixReady;
    logic        r_frameStart;
    logic        r_underflow;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .o_h          (w_hCount),
        .o_hsAct      (w_hsAct),
        .o_vsAct      (w_vsAct),
        .o_activeLine (w_activeLine),
        .o_origin     (w_origin)
    );

    assign w_videoWin  = i_en && w_activeLine && (w_hCount >= L_H_BLANK);
    assign w_readyNext = i_en && w_activeLine && (w_hCount >= L_RDY_FIRST) && (w_hCount <= L_RDY_LAST);

`ifdef TMDS_HDMI_PERIODS_EN
    localparam logic [11:0] L_PRE_FIRST = 12'(H_FP + H_SYNC + H_BP - 10);
    localparam logic [11:0] L_PRE_LAST  = 12'(H_FP + H_SYNC + H_BP - 3);
    localparam logic [11:0] L_GRD_FIRST = 12'(H_FP + H_SYNC + H_BP - 2);

    logic w_preambleWin;
    logic w_guardWin;

    assign w_preambleWin = i_en && w_activeLine && (w_hCount >= L_PRE_FIRST) && (w_hCount <= L_PRE_LAST);
    assign w_guardWin    = i_en && w_activeLine && (w_hCount >= L_GRD_FIRST) && (w_hCount < L_H_BLANK);
`endif

    // A pixel accepted on this edge lands on the data registers in the same
    // update that moves the mode to VIDEO, keeping all channels aligned.
    always_comb begin
        w_modeNext  = CONTROL;
        w_ctrl0Next = {(i_en && w_vsAct) ? L_VS_ON : ~L_VS_ON,
                       (i_en && w_hsAct) ? L_HS_ON : ~L_HS_ON};
        w_ctrl1Next = 2'b00;
        w_ctrl2Next = 2'b00;
        w_pixNext   = '0;
        if (w_videoWin) begin
            w_modeNext = VIDEO;
            if (r_pixReady && i_pix_valid) begin
                w_pixNext = i_pix;
            end
        end
`ifdef TMDS_HDMI_PERIODS_EN
        else if (w_preambleWin) begin
            w_modeNext  = PREAMBLE;
            w_ctrl1Next = PREAMBLE_VIDEO_CTL[1:0];
            w_ctrl2Next = PREAMBLE_VIDEO_CTL[3:2];
        end else if (w_guardWin) begin
            w_modeNext = GUARD;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode       <= CONTROL;
            r_ctrl0      <= {~L_VS_ON, ~L_HS_ON};
            r_ctrl1      <= 2'b00;
            r_ctrl2      <= 2'b00;
            r_pix        <= '0;
            r_pixReady   <= 1'b0;
            r_frameStart <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_mode       <= w_modeNext;
            r_ctrl0      <= w_ctrl0Next;
            r_ctrl1      <= w_ctrl1Next;
            r_ctrl2      <= w_ctrl2Next;
            r_pix        <= w_pixNext;
            r_pixReady   <= w_readyNext;
            r_frameStart <= i_en && w_origin;
            if (r_pixReady && !i_pix_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_mode        = r_mode;
    assign o_ctrl0       = r_ctrl0;
    assign o_ctrl1       = r_ctrl1;
    assign o_ctrl2       = r_ctrl2;
    assign o_data2       = r_pix[23:16];
    assign o_data1       = r_pix[15:8];
    assign o_data0       = r_pix[7:0];
    assign o_pix_ready   = r_pixReady;
    assign o_frame_start = r_frameStart;
    assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_tmds_period_scheduler.sv
// Directed table-driven bench for tmds_period_scheduler on a 24x6 raster,
// plus hand sequences for enable drop and asynchronous reset mid-line.
module tb_tmds_period_scheduler;

    localparam int HT = 24;
    localparam int FT = 24 * 6;

`ifdef TMDS_HDMI_PERIODS_EN
    localparam logic [1:0] PRE_M  = 2'b01;
    localparam logic [1:0] GRD_M  = 2'b10;
    localparam logic [1:0] PRE_C1 = 2'b01;
`else
    localparam logic [1:0] PRE_M  = 2'b00;
    localparam logic [1:0] GRD_M  = 2'b00;
    localparam logic [1:0] PRE_C1 = 2'b00;
`endif

    typedef struct {
        int         f;
        int         v;
        int         h;
        logic [1:0] mode;
        logic [1:0] ctrl0;
        logic [1:0] ctrl1;
        logic       rdy;
        logic [7:0] d0;
        logic [7:0] d2;
        logic       uf;
        logic       fs;
    } vec_t;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic [23:0] i_pix;
    logic        i_pix_valid;
    logic        o_pix_ready;
    logic [1:0]  o_mode;
    logic [1:0]  o_ctrl0, o_ctrl1, o_ctrl2;
    logic [7:0]  o_data0, o_data1, o_data2;
    logic        o_frame_start;
    logic        o_underflow;

    int   compared;
    int   mismatched;
    int   k;
    vec_t vecs[$];

    tmds_period_scheduler #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (2),
        .H_BP     (12),
        .V_ACTIVE (3),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .HS_POL   (0),
        .VS_POL   (0)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (i_en),
        .i_pix         (i_pix),
        .i_pix_valid   (i_pix_valid),
        .o_pix_ready   (o_pix_ready),
        .o_mode        (o_mode),
        .o_ctrl0       (o_ctrl0),
        .o_ctrl1       (o_ctrl1),
        .o_ctrl2       (o_ctrl2),
        .o_data0       (o_data0),
        .o_data1       (o_data1),
        .o_data2       (o_data2),
        .o_frame_start (o_frame_start),
        .o_underflow   (o_underflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input int f, input int v, input int h, input logic [1:0] mode,
                          input logic [1:0] c0, input logic [1:0] c1, input logic rdy,
                          input logic [7:0] d0, input logic [7:0] d2, input logic uf, input logic fs);
        vec_t e;
        e.f = f; e.v = v; e.h = h; e.mode = mode; e.ctrl0 = c0; e.ctrl1 = c1;
        e.rdy = rdy; e.d0 = d0; e.d2 = d2; e.uf = uf; e.fs = fs;
        vecs.push_back(e);
    endtask

    // Pixel x of a line is {A0+x, 50+x, x}; driven while the position before it is shown.
    task automatic applyStimulus();
        int f, v, h;
        logic [7:0] x;
        x = 8'h00;
        i_pix_valid = 1'b1;
        if (k >= 0) begin
            f = k / FT;
            v = (k % FT) / HT;
            h = k % HT;
            x = 8'(h - 14);
            i_pix_valid = !(f == 1 && v == 4 && h == 18);
        end
        i_pix = {8'hA0 + x, 8'h50 + x, x};
        @(posedge i_clk);
        #1;
        k++;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " mode"}, 32'(o_mode), 32'h0);
        checkOutput({tag, " ctrl0"}, 32'(o_ctrl0), 32'h3);
        checkOutput({tag, " ctrl1"}, 32'(o_ctrl1), 32'h0);
        checkOutput({tag, " ctrl2"}, 32'(o_ctrl2), 32'h0);
        checkOutput({tag, " data"}, 32'({o_data2, o_data1, o_data0}), 32'h0);
        checkOutput({tag, " ready"}, 32'(o_pix_ready), 32'h0);
        checkOutput({tag, " frame_start"}, 32'(o_frame_start), 32'h0);
        checkOutput({tag, " underflow"}, 32'(o_underflow), 32'h0);
    endtask

    initial begin
        string tag;
        int    target;
        compared    = 0;
        mismatched  = 0;
        k           = -1;
        i_rst_n     = 1'b0;
        i_en        = 1'b0;
        i_pix       = '0;
        i_pix_valid = 1'b1;

        //           f v  h  mode   ctrl0  ctrl1   rdy d0     d2     uf fs
        addVec(0, 0, 0,  2'b00, 2'b11, 2'b00,  0, 8'h00, 8'h00, 0, 1);
        addVec(0, 0, 2,  2'b00, 2'b10, 2'b00,  0, 8'h00, 8'h00, 0, 0);
        addVec(0, 0, 3,  2'b00, 2'b10, 2'b00,  0, 8'h00, 8'h00, 0, 0);
        addVec(0, 0, 4,  2'b00, 2'b11, 2'b00,  0, 8'h00, 8'h00, 0, 0);
        addVec(0, 0, 16, 2'b00, 2'b11, 2'b00,  0, 8'h00, 8'h00, 0, 0);
        addVec(0, 0, 22, 2'b00, 2'b11, 2'b00,  0, 8'h00, 8'h00, 0, 0);
        addVec(0, 1, 0,  2'b00, 2'b01, 2'b00,  0, 8'h00, 8'h00, 0, 0);
        addVec(0, 1, 2,  2'b00, 2'b00, 2'b00,  0, 8'h00, 8'h00, 0, 0);
        addVec(0, 2, 0,  2'b00, 2'b11, 2'b00,  0, 8'h00, 8'h00, 0, 0);
        addVec(0, 3, 5,  2'b00, 2'b11, 2'b00,  0, 8'h00, 8'h00, 0, 0);
        addVec(0, 3, 6,  PRE_M, 2'b11, PRE_C1, 0, 8'h00, 8'h00, 0, 0);
        addVec(0, 3, 13, PRE_M, 2'b11, PRE_C1, 0, 8'h00, 8'h00, 0, 0);
        addVec(0, 3, 14, GRD_M, 2'b11, 2'b00,  0, 8'h00, 8'h00, 0, 0);
        addVec(0, 3, 15, GRD_M, 2'b11, 2'b00,  1, 8'h00, 8'h00, 0, 0);
        addVec(0, 3, 16, 2'b11, 2'b11, 2'b00,  1, 8'h01, 8'hA1, 0, 0);
        addVec(0, 3, 19, 2'b11, 2'b11, 2'b00,  1, 8'h04, 8'hA4, 0, 0);
        addVec(0, 3, 22, 2'b11, 2'b11, 2'b00,  1, 8'h07, 8'hA7, 0, 0);
        addVec(0, 3, 23, 2'b11, 2'b11, 2'b00,  0, 8'h08, 8'hA8, 0, 0);
        addVec(0, 4, 0,  2'b00, 2'b11, 2'b00,  0, 8'h00, 8'h00, 0, 0);
        addVec(0, 5, 16, 2'b11, 2'b11, 2'b00,  1, 8'h01, 8'hA1, 0, 0);
        addVec(1, 0, 0,  2'b00, 2'b11, 2'b00,  0, 8'h00, 8'h00, 0, 1);
        addVec(1, 4, 18, 2'b11, 2'b11, 2'b00,  1, 8'h03, 8'hA3, 0, 0);
        addVec(1, 4, 19, 2'b11, 2'b11, 2'b00,  1, 8'h00, 8'h00, 1, 0);
        addVec(1, 4, 20, 2'b11, 2'b11, 2'b00,  1, 8'h05, 8'hA5, 1, 0);
        addVec(2, 0, 0,  2'b00, 2'b11, 2'b00,  0, 8'h00, 8'h00, 1, 1);
        addVec(2, 3, 16, 2'b11, 2'b11, 2'b00,  1, 8'h01, 8'hA1, 1, 0);

        // Reset held, then released while disabled: nothing may start.
        repeat (2) @(posedge i_clk);
        #1;
        checkResetValues("reset");
        #3 i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("idle mode", 32'(o_mode), 32'h0);
        checkOutput("idle frame_start", 32'(o_frame_start), 32'h0);
        checkOutput("idle ready", 32'(o_pix_ready), 32'h0);
        checkOutput("idle ctrl0", 32'(o_ctrl0), 32'h3);

        i_en = 1'b1;
        foreach (vecs[i]) begin
            target = vecs[i].f * FT + vecs[i].v * HT + vecs[i].h;
            while (k < target) applyStimulus();
            tag = $sformatf("f%0d v%0d h%0d", vecs[i].f, vecs[i].v, vecs[i].h);
            checkOutput({tag, " mode"}, 32'(o_mode), 32'(vecs[i].mode));
            if (vecs[i].mode != 2'b11) checkOutput({tag, " ctrl0"}, 32'(o_ctrl0), 32'(vecs[i].ctrl0));
            checkOutput({tag, " ctrl1"}, 32'(o_ctrl1), 32'(vecs[i].ctrl1));
            checkOutput({tag, " ctrl2"}, 32'(o_ctrl2), 32'h0);
            checkOutput({tag, " ready"}, 32'(o_pix_ready), 32'(vecs[i].rdy));
            checkOutput({tag, " data0"}, 32'(o_data0), 32'(vecs[i].d0));
            checkOutput({tag, " data2"}, 32'(o_data2), 32'(vecs[i].d2));
            checkOutput({tag, " underflow"}, 32'(o_underflow), 32'(vecs[i].uf));
            checkOutput({tag, " frame_start"}, 32'(o_frame_start), 32'(vecs[i].fs));
        end

        // Enable dropped inside the video window aborts on the next edge.
        applyStimulus();
        i_en = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("en-drop mode", 32'(o_mode), 32'h0);
        checkOutput("en-drop ready", 32'(o_pix_ready), 32'h0);
        checkOutput("en-drop data0", 32'(o_data0), 32'h0);
        checkOutput("en-drop ctrl0", 32'(o_ctrl0), 32'h3);
        @(posedge i_clk);
        #1;
        checkOutput("en-low frame_start", 32'(o_frame_start), 32'h0);
        k = -1;
        i_en = 1'b1;
        applyStimulus();
        checkOutput("re-enable frame_start", 32'(o_frame_start), 32'h1);
        checkOutput("re-enable mode", 32'(o_mode), 32'h0);

        // Asynchronous reset at v=4 h=17 clears everything before the next edge.
        while (k < 4 * HT + 17) applyStimulus();
        checkOutput("pre-reset mode", 32'(o_mode), 32'h3);
        checkOutput("pre-reset underflow", 32'(o_underflow), 32'h1);
        #3 i_rst_n = 1'b0;
        #1;
        checkResetValues("async-reset");
        @(posedge i_clk);
        #1;
        checkOutput("reset-held frame_start", 32'(o_frame_start), 32'h0);
        #3 i_rst_n = 1'b1;
        k = -1;
        applyStimulus();
        checkOutput("post-reset frame_start", 32'(o_frame_start), 32'h1);
        applyStimulus();
        checkOutput("post-reset frame_start drop", 32'(o_frame_start), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
